// File: rtl/alu_core_pkg.sv
// alu_core_pkg
//   Shared definitions for the registered ALU: the 4-bit function codes
//   decoded by alu_core_comb and the fixed values returned by the compare
//   operations.
package alu_core_pkg;

    localparam logic [3:0] FUN_ADD  = 4'h0;
    localparam logic [3:0] FUN_SUB  = 4'h1;
    localparam logic [3:0] FUN_MUL  = 4'h2;
    localparam logic [3:0] FUN_DIV  = 4'h3;
    localparam logic [3:0] FUN_AND  = 4'h4;
    localparam logic [3:0] FUN_OR   = 4'h5;
    localparam logic [3:0] FUN_NAND = 4'h6;
    localparam logic [3:0] FUN_NOR  = 4'h7;
    localparam logic [3:0] FUN_XOR  = 4'h8;
    localparam logic [3:0] FUN_XNOR = 4'h9;
    localparam logic [3:0] FUN_CEQ  = 4'hA;
    localparam logic [3:0] FUN_CGT  = 4'hB;
    localparam logic [3:0] FUN_CLT  = 4'hC;
    localparam logic [3:0] FUN_SHR  = 4'hD;
    localparam logic [3:0] FUN_SHL  = 4'hE;
    localparam logic [3:0] FUN_NOP  = 4'hF;

    // Values written to the result when a compare holds (0 otherwise).
    localparam int CMP_EQ_VAL = 1;
    localparam int CMP_GT_VAL = 2;
    localparam int CMP_LT_VAL = 3;

endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb
//   Purely combinational result selector. Operands are zero-extended to
//   double width before every operation, so all results wrap modulo
//   2^(2*OPERAND_WIDTH) and the bitwise inverting ops set the upper half.
// Ports:
//   a_i, b_i   unsigned operands
//   fun_i      function code (see alu_core_pkg)
//   res_o      double-width result for the next register load
module alu_core_comb
    import alu_core_pkg::*;
#(
    parameter int OPERAND_WIDTH = 8,
    parameter int FUN_WIDTH     = 4
) (
    input  logic [OPERAND_WIDTH-1:0]   a_i,
    input  logic [OPERAND_WIDTH-1:0]   b_i,
    input  logic [FUN_WIDTH-1:0]       fun_i,
    output logic [2*OPERAND_WIDTH-1:0] res_o
);

    localparam int RW = 2 * OPERAND_WIDTH;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [3:0]    fun;

    assign a_ext = {{OPERAND_WIDTH{1'b0}}, a_i};
    assign b_ext = {{OPERAND_WIDTH{1'b0}}, b_i};
    // Only the low four bits carry a defined operation.
    assign fun   = fun_i[3:0];

    always_comb begin
        res_o = '0;
        case (fun)
            FUN_ADD:  res_o = a_ext + b_ext;
            FUN_SUB:  res_o = a_ext - b_ext;
            // Product of two N-bit values always fits in 2N bits.
            FUN_MUL:  res_o = a_ext * b_ext;
            // Divide by zero returns 0 rather than an undefined quotient.
            FUN_DIV:  res_o = (b_i == '0) ? '0 : (a_ext / b_ext);
            FUN_AND:  res_o = a_ext & b_ext;
            FUN_OR:   res_o = a_ext | b_ext;
            FUN_NAND: res_o = ~(a_ext & b_ext);
            FUN_NOR:  res_o = ~(a_ext | b_ext);
            FUN_XOR:  res_o = a_ext ^ b_ext;
            FUN_XNOR: res_o = ~(a_ext ^ b_ext);
            FUN_CEQ:  res_o = (a_i == b_i) ? RW'(CMP_EQ_VAL) : '0;
            FUN_CGT:  res_o = (a_i >  b_i) ? RW'(CMP_GT_VAL) : '0;
            FUN_CLT:  res_o = (a_i <  b_i) ? RW'(CMP_LT_VAL) : '0;
            FUN_SHR:  res_o = a_ext >> 1;
            // Shift happens in the wide domain, so the carried-out bit survives.
            FUN_SHL:  res_o = a_ext << 1;
            FUN_NOP:  res_o = '0;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// alu_core
//   Registered ALU on a gated clock. An edge with Enable=1 loads the
//   selected result and raises OUT_VALID for that cycle; an edge with
//   Enable=0 drops OUT_VALID and keeps the last result so the controller
//   can still read it a cycle later. Only state is the two output
//   registers, so a stopped clock simply freezes the outputs.
// Ports:
//   CLK        gated ALU clock
//   RST        synchronous active-high reset, overrides Enable
//   A, B       unsigned operands
//   ALU_FUN    function code
//   Enable     execute request (level)
//   ALU_OUT    registered double-width result
//   OUT_VALID  registered result-valid flag
module alu_core
    import alu_core_pkg::*;
#(
    parameter int OPERAND_WIDTH = 8,
    parameter int FUN_WIDTH     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [OPERAND_WIDTH-1:0]   A,
    input  logic [OPERAND_WIDTH-1:0]   B,
    input  logic [FUN_WIDTH-1:0]       ALU_FUN,
    input  logic                       Enable,
    output logic [2*OPERAND_WIDTH-1:0] ALU_OUT,
    output logic                       OUT_VALID
);

    localparam int RW = 2 * OPERAND_WIDTH;

    logic [RW-1:0] res_w;
    logic [RW-1:0] alu_out_d;
    logic [RW-1:0] alu_out_q;
    logic          out_valid_d;
    logic          out_valid_q;

    alu_core_comb #(
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .FUN_WIDTH     (FUN_WIDTH)
    ) u_comb (
        .a_i   (A),
        .b_i   (B),
        .fun_i (ALU_FUN),
        .res_o (res_w)
    );

    // Result is held when idle; valid tracks Enable one edge later.
    always_comb begin
        alu_out_d   = Enable ? res_w : alu_out_q;
        out_valid_d = Enable;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ALU_OUT   = alu_out_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        CLK;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        Enable;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;

    int checks;
    int errors;
    bit clk_run;
    int edge_cnt;

    alu_core #(
        .OPERAND_WIDTH (8),
        .FUN_WIDTH     (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .Enable    (Enable),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID)
    );

    // Gateable clock: when clk_run is low the clock stays at its level.
    initial begin
        CLK = 1'b0;
        forever begin
            #5;
            if (clk_run) CLK = ~CLK;
        end
    end

    always @(posedge CLK) edge_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // One active edge, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; Enable = 1'b1; A = 8'h10; B = 8'h20; ALU_FUN = 4'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL reset_edge%0d: out=%h vld=%b required out=0000 vld=0", i, ALU_OUT, OUT_VALID);
            end
        end
        RST = 1'b0;
        tick();
        checks++;
        if (ALU_OUT !== 16'h0030 || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: out=%h vld=%b required out=0030 vld=1", ALU_OUT, OUT_VALID);
        end
    endtask

    task automatic test_arith();
        logic [7:0]  ta [5] = '{8'hFF, 8'hFF, 8'd3,  8'd20, 8'd20};
        logic [7:0]  tb [5] = '{8'hFF, 8'hFF, 8'd5,  8'd6,  8'd0};
        logic [3:0]  tf [5] = '{4'h0,  4'h2,  4'h1,  4'h3,  4'h3};
        logic [15:0] te [5] = '{16'h01FE, 16'hFE01, 16'hFFFE, 16'h0003, 16'h0000};
        Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            A = ta[i]; B = tb[i]; ALU_FUN = tf[i];
            tick();
            checks++;
            if (ALU_OUT !== te[i] || OUT_VALID !== 1'b1) begin
                errors++;
                $display("FAIL arith_fun%h: out=%h vld=%b required out=%h vld=1", tf[i], ALU_OUT, OUT_VALID, te[i]);
            end
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  tf [8] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD, 4'hE};
        logic [15:0] te [8] = '{16'h0030, 16'h00FC, 16'hFFCF, 16'hFF03,
                                16'h00CC, 16'hFF33, 16'h0078, 16'h01E0};
        Enable = 1'b1; A = 8'hF0; B = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            ALU_FUN = tf[i];
            tick();
            checks++;
            if (ALU_OUT !== te[i] || OUT_VALID !== 1'b1) begin
                errors++;
                $display("FAIL logic_fun%h: out=%h vld=%b required out=%h vld=1", tf[i], ALU_OUT, OUT_VALID, te[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [7:0]  ta [6] = '{8'd7, 8'd7, 8'd9, 8'd9, 8'd4, 8'd9};
        logic [7:0]  tb [6] = '{8'd7, 8'd7, 8'd4, 8'd4, 8'd9, 8'd4};
        logic [3:0]  tf [6] = '{4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hF};
        logic [15:0] te [6] = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 16'd0};
        Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            A = ta[i]; B = tb[i]; ALU_FUN = tf[i];
            tick();
            checks++;
            if (ALU_OUT !== te[i] || OUT_VALID !== 1'b1) begin
                errors++;
                $display("FAIL cmp_fun%h_a%0d_b%0d: out=%h vld=%b required out=%h vld=1",
                         tf[i], ta[i], tb[i], ALU_OUT, OUT_VALID, te[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        Enable = 1'b1; A = 8'd5; B = 8'd6; ALU_FUN = 4'h0;
        tick();
        checks++;
        if (ALU_OUT !== 16'h000B || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: out=%h vld=%b required out=000b vld=1", ALU_OUT, OUT_VALID);
        end
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 8'(8'h21 + i * 8'h13); B = 8'(8'h77 - i);
            tick();
            checks++;
            if (ALU_OUT !== 16'h000B || OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle%0d: out=%h vld=%b required out=000b vld=0", i, ALU_OUT, OUT_VALID);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Continuous mode: inputs change every edge, each edge gets its own result.
        logic [7:0]  ta [3] = '{8'd1,  8'd200, 8'd17};
        logic [7:0]  tb [3] = '{8'd2,  8'd100, 8'd3};
        logic [3:0]  tf [3] = '{4'h0,  4'h1,   4'h2};
        logic [15:0] te [3] = '{16'd3, 16'd100, 16'd51};
        Enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = ta[i]; B = tb[i]; ALU_FUN = tf[i];
            tick();
            checks++;
            if (ALU_OUT !== te[i] || OUT_VALID !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: out=%h vld=%b required out=%h vld=1", i, ALU_OUT, OUT_VALID, te[i]);
            end
        end
    endtask

    task automatic test_gated_clock();
        int cnt0;
        Enable = 1'b1; A = 8'd12; B = 8'd12; ALU_FUN = 4'h2;
        tick();
        checks++;
        if (ALU_OUT !== 16'h0090 || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL gate_mul: out=%h vld=%b required out=0090 vld=1", ALU_OUT, OUT_VALID);
        end
        @(negedge CLK);
        clk_run = 1'b0;
        cnt0 = edge_cnt;
        A = 8'h55; B = 8'hAA; ALU_FUN = 4'h0;
        #100;
        checks++;
        if (edge_cnt !== cnt0 || ALU_OUT !== 16'h0090 || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL gate_stopped: edges=%0d out=%h vld=%b required edges=%0d out=0090 vld=1",
                     edge_cnt, ALU_OUT, OUT_VALID, cnt0);
        end
        Enable = 1'b0;
        clk_run = 1'b1;
        tick();
        checks++;
        if (edge_cnt !== cnt0 + 1 || ALU_OUT !== 16'h0090 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL gate_resume: edges=%0d out=%h vld=%b required edges=%0d out=0090 vld=0",
                     edge_cnt, ALU_OUT, OUT_VALID, cnt0 + 1);
        end
    endtask

    task automatic test_reset_mid_op();
        Enable = 1'b1; A = 8'd9; B = 8'd9; ALU_FUN = 4'h0;
        tick();
        RST = 1'b1; A = 8'd40; B = 8'd2;
        tick();
        checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: out=%h vld=%b required out=0000 vld=0", ALU_OUT, OUT_VALID);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (ALU_OUT !== 16'h002A || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op_after: out=%h vld=%b required out=002a vld=1", ALU_OUT, OUT_VALID);
        end
    endtask

    initial begin
        checks = 0; errors = 0; edge_cnt = 0;
        clk_run = 1'b1;
        RST = 1'b1; Enable = 1'b0; A = '0; B = '0; ALU_FUN = '0;
        #1;
        test_reset();
        test_arith();
        test_logic_shift();
        test_compare();
        test_enable_hold();
        test_back_to_back();
        test_gated_clock();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
